// File: rtl/facing_turn_controller_if.sv
// Bundle of game-frame inputs and facing/turn outputs between the movement logic and the
// sprite renderer. The master drives the positions; the slave is the facing controller.
interface facing_turn_controller_if;
  logic       frame_tick;
  logic [6:0] sprite1_x;
  logic [6:0] sprite2_x;
  logic       p1_busy;
  logic       p2_busy;
  logic       sprite1_facing_right;
  logic       sprite2_facing_right;
  logic       p1_turning;
  logic       p2_turning;
  logic       p1_turn_start;
  logic       p2_turn_start;

  modport master (
    output frame_tick,
    output sprite1_x,
    output sprite2_x,
    output p1_busy,
    output p2_busy,
    input  sprite1_facing_right,
    input  sprite2_facing_right,
    input  p1_turning,
    input  p2_turning,
    input  p1_turn_start,
    input  p2_turn_start
  );

  modport slave (
    input  frame_tick,
    input  sprite1_x,
    input  sprite2_x,
    input  p1_busy,
    input  p2_busy,
    output sprite1_facing_right,
    output sprite2_facing_right,
    output p1_turning,
    output p2_turning,
    output p1_turn_start,
    output p2_turn_start
  );
endinterface

// File: rtl/facing_turn_controller.sv
// Debounced, busy-gated fighter turnarounds with a fixed-length turn animation per player.
// Define FACING_HYST_EN to require HYST_FRAMES eligible ticks before a turn (else the first).
module facing_turn_controller #(
  parameter int unsigned DEADBAND    = 2,
  parameter int unsigned HYST_FRAMES = 3,
  parameter int unsigned TURN_FRAMES = 4
) (
  input logic                     clk,
  input logic                     reset,
  facing_turn_controller_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPending, StTurning} state_e;

  localparam logic [7:0] Deadband  = 8'(DEADBAND);
  localparam logic [3:0] TurnLimit = 4'(TURN_FRAMES);
`ifdef FACING_HYST_EN
  localparam logic [3:0] HystLimit = 4'(HYST_FRAMES);
`else
  localparam logic [3:0] HystLimit = 4'd1;
`endif

  logic [7:0] x1, x2;
  logic       p1_left_q, p1_left_d;

  // Index 0 is player 1, index 1 is player 2.
  state_e     state_q [2];
  state_e     state_d [2];
  logic [3:0] cnt_q   [2];
  logic [3:0] cnt_d   [2];
  logic [1:0] facing_q, facing_d;
  logic [1:0] turning_q, turning_d;
  logic [1:0] start_q, start_d;
  logic [1:0] desired, busy;

  assign x1 = {1'b0, bus.sprite1_x};
  assign x2 = {1'b0, bus.sprite2_x};

  // Separation within the deadband keeps the previous side, so sprites standing close don't flicker.
  always_comb begin
    p1_left_d = p1_left_q;
    if (x1 + Deadband < x2) begin
      p1_left_d = 1'b1;
    end else if (x2 + Deadband < x1) begin
      p1_left_d = 1'b0;
    end
  end

  assign desired = {~p1_left_q, p1_left_q};
  assign busy    = {bus.p2_busy, bus.p1_busy};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      facing_d[i]  = facing_q[i];
      turning_d[i] = turning_q[i];
      start_d[i]   = 1'b0;

      unique case (state_q[i])
        StIdle: begin
          if (desired[i] != facing_q[i]) begin
            state_d[i] = StPending;
            cnt_d[i]   = 4'd0;
          end
        end
        StPending: begin
          if (desired[i] == facing_q[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = 4'd0;
          end else if (bus.frame_tick && !busy[i]) begin
            if (cnt_q[i] + 4'd1 == HystLimit) begin
              state_d[i]   = StTurning;
              cnt_d[i]     = 4'd0;
              facing_d[i]  = ~facing_q[i];
              turning_d[i] = 1'b1;
              start_d[i]   = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 4'd1;
            end
          end
        end
        StTurning: begin
          // Position and busy are deliberately ignored until the animation finishes.
          if (bus.frame_tick) begin
            if (cnt_q[i] + 4'd1 == TurnLimit) begin
              state_d[i]   = StIdle;
              cnt_d[i]     = 4'd0;
              turning_d[i] = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] + 4'd1;
            end
          end
        end
        default: begin
          state_d[i]   = StIdle;
          cnt_d[i]     = 4'd0;
          turning_d[i] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_left_q  <= 1'b1;
      state_q[0] <= StIdle;
      state_q[1] <= StIdle;
      cnt_q[0]   <= 4'd0;
      cnt_q[1]   <= 4'd0;
      facing_q   <= 2'b01;
      turning_q  <= 2'b00;
      start_q    <= 2'b00;
    end else begin
      p1_left_q  <= p1_left_d;
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      facing_q   <= facing_d;
      turning_q  <= turning_d;
      start_q    <= start_d;
    end
  end

  assign bus.sprite1_facing_right = facing_q[0];
  assign bus.sprite2_facing_right = facing_q[1];
  assign bus.p1_turning           = turning_q[0];
  assign bus.p2_turning           = turning_q[1];
  assign bus.p1_turn_start        = start_q[0];
  assign bus.p2_turn_start        = start_q[1];

endmodule

// File: tb/tb_facing_turn_controller.sv
// Directed bench for facing_turn_controller; expectations adapt to whether FACING_HYST_EN is set.
module tb_facing_turn_controller;

`ifdef FACING_HYST_EN
  localparam int Hyst = 3;
`else
  localparam int Hyst = 1;
`endif
  localparam int Turn = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  facing_turn_controller_if bus ();

  facing_turn_controller #(
    .DEADBAND   (2),
    .HYST_FRAMES(3),
    .TURN_FRAMES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Two quiet cycles, then a one-cycle frame tick; returns just after the tick edge.
  task automatic tick();
    step(2);
    bus.frame_tick = 1'b1;
    step(1);
    bus.frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Vectors are {player2, player1}.
  task automatic chk_out(input string tag, input logic [1:0] face, input logic [1:0] turn,
                         input logic [1:0] start);
    chk({tag, "_face"}, {bus.sprite2_facing_right, bus.sprite1_facing_right}, face);
    chk({tag, "_turn"}, {bus.p2_turning, bus.p1_turning}, turn);
    chk({tag, "_start"}, {bus.p2_turn_start, bus.p1_turn_start}, start);
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.sprite1_x  = 7'd10;
    bus.sprite2_x  = 7'd100;
    bus.p1_busy    = 1'b0;
    bus.p2_busy    = 1'b0;

    // Reset and idle frames
    step(2);
    chk_out("reset", 2'b01, 2'b00, 2'b00);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("reset_idle", 2'b01, 2'b00, 2'b00);
    end

    // Clean crossing
    bus.sprite1_x = 7'd100;
    bus.sprite2_x = 7'd10;
    for (int i = 1; i < Hyst; i++) begin
      tick();
      chk_out("cross_wait", 2'b01, 2'b00, 2'b00);
    end
    tick();
    chk_out("cross_flip", 2'b10, 2'b11, 2'b11);
    step(1);
    chk_out("cross_pulse_end", 2'b10, 2'b11, 2'b00);
    for (int i = 1; i < Turn; i++) begin
      tick();
      chk_out("turn_hold", 2'b10, 2'b11, 2'b00);
    end
    tick();
    chk_out("turn_end", 2'b10, 2'b00, 2'b00);
    tick();
    chk_out("post_turn", 2'b10, 2'b00, 2'b00);

    // Deadband hold
    bus.sprite1_x = 7'd50;
    bus.sprite2_x = 7'd51;
    do_reset();
    for (int i = 0; i <= Hyst; i++) begin
      tick();
      chk_out("deadband_close", 2'b01, 2'b00, 2'b00);
    end
    bus.sprite1_x = 7'd52;
    bus.sprite2_x = 7'd50;
    for (int i = 0; i <= Hyst; i++) begin
      tick();
      chk_out("deadband_edge", 2'b01, 2'b00, 2'b00);
    end
    bus.sprite1_x = 7'd53;
    for (int i = 1; i < Hyst; i++) begin
      tick();
      chk_out("deadband_pend", 2'b01, 2'b00, 2'b00);
    end
    tick();
    chk_out("deadband_flip", 2'b10, 2'b11, 2'b11);
    for (int i = 0; i < Turn; i++) tick();
    chk_out("deadband_done", 2'b10, 2'b00, 2'b00);

    // Busy blocks player 1 only
    bus.sprite1_x = 7'd10;
    bus.sprite2_x = 7'd100;
    do_reset();
    bus.sprite1_x = 7'd100;
    bus.sprite2_x = 7'd10;
    bus.p1_busy   = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("busy_face", {bus.sprite2_facing_right, bus.sprite1_facing_right},
          (i >= Hyst) ? 2'b11 : 2'b01);
      chk("busy_turn", {bus.p2_turning, bus.p1_turning},
          {(i >= Hyst && i < Hyst + Turn), 1'b0});
      chk("busy_start", {bus.p2_turn_start, bus.p1_turn_start},
          (i == Hyst) ? 2'b10 : 2'b00);
    end
    bus.p1_busy = 1'b0;
    for (int i = 1; i < Hyst; i++) begin
      tick();
      chk("busy_release_wait", {bus.sprite2_facing_right, bus.sprite1_facing_right}, 2'b11);
    end
    tick();
    chk_out("busy_p1_flip", 2'b10, 2'b01, 2'b01);
    for (int i = 0; i < Turn; i++) tick();
    chk_out("busy_done", 2'b10, 2'b00, 2'b00);

    // Abort restores IDLE and clears the count
    bus.sprite1_x = 7'd10;
    bus.sprite2_x = 7'd100;
    do_reset();
    bus.sprite1_x = 7'd100;
    bus.sprite2_x = 7'd10;
    for (int i = 1; i < Hyst; i++) begin
      tick();
      chk_out("abort_pend", 2'b01, 2'b00, 2'b00);
    end
    bus.sprite1_x = 7'd10;
    bus.sprite2_x = 7'd100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("abort_idle", 2'b01, 2'b00, 2'b00);
    end
    bus.sprite1_x = 7'd100;
    bus.sprite2_x = 7'd10;
    for (int i = 1; i < Hyst; i++) begin
      tick();
      chk_out("recross_wait", 2'b01, 2'b00, 2'b00);
    end
    tick();
    chk_out("recross_flip", 2'b10, 2'b11, 2'b11);

    // Reset on turn tick 2, coincident with frame_tick
    tick();
    chk_out("midturn_tick1", 2'b10, 2'b11, 2'b00);
    step(2);
    bus.sprite1_x  = 7'd10;
    bus.sprite2_x  = 7'd100;
    reset          = 1'b1;
    bus.frame_tick = 1'b1;
    step(1);
    bus.frame_tick = 1'b0;
    reset          = 1'b0;
    chk_out("midturn_reset", 2'b01, 2'b00, 2'b00);
    tick();
    chk_out("after_reset", 2'b01, 2'b00, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/facing_turn_controller.md
# facing_turn_controller

Sequences fighter turnarounds for the two-player game logic. It watches both sprites' x positions and commits a facing change only when these conditions hold: the positions have clearly crossed, the crossing has been stable for a number of frames, and the fighter is not locked in an action. During a turn it raises a per-player `turning` flag for a fixed number of frames so the sprite renderer can play a turn animation. It sits between the position/movement logic and the sprite renderer, and replaces the purely combinational facing decision.

## Interface
Parameters:
- `DEADBAND`, 2: minimum x separation in pixels before sides are considered swapped (0–15).
- `HYST_FRAMES`, 3: consecutive eligible frames a crossing must persist before a turn starts (1–15).
- `TURN_FRAMES`, 4: frames the `turning` flag stays high per turn (1–15).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: single-cycle pulse, once per game frame.
- `sprite1_x` in 7: player 1 x position.
- `sprite2_x` in 7: player 2 x position.
- `p1_busy` in 1: player 1 attacking, jumping or in hitstun; turn not allowed.
- `p2_busy` in 1: same for player 2.
- `sprite1_facing_right` out 1: player 1 facing.
- `sprite2_facing_right` out 1: player 2 facing.
- `p1_turning` out 1: player 1 turn animation active.
- `p2_turning` out 1: player 2 turn animation active.
- `p1_turn_start` out 1: one-cycle pulse when player 1 facing flips.
- `p2_turn_start` out 1: one-cycle pulse when player 2 facing flips.

## Operation
- **Side register `p1_left`** (reset 1), updated every clock:
  - Set to 1 if `{1'b0,sprite1_x} + DEADBAND < {1'b0,sprite2_x}`.
  - Cleared to 0 if `{1'b0,sprite2_x} + DEADBAND < {1'b0,sprite1_x}`.
  - Otherwise holds its value.
  - All comparisons are 8-bit, so there is no wrap-around.
- **Desired facing:** player 1 wants `p1_left`; player 2 wants `~p1_left`.
- **Per-player FSM:** two identical, independent instances. Each has a 4-bit counter `cnt`.
  - **IDLE:**
    - If desired != current facing, go to PENDING with `cnt`=0.
    - Otherwise stay.
  - **PENDING:**
    - If desired == current facing in any cycle, go to IDLE and clear `cnt`.
    - Else, on `frame_tick` with busy=0, increment `cnt`.
    - When the incremented value equals `HYST_FRAMES`: go to TURNING, flip facing, pulse `turn_start`, load `cnt`=0.
    - On `frame_tick` with busy=1, `cnt` holds.
  - **TURNING:**
    - `turning`=1.
    - Position changes and busy are ignored.
    - Each `frame_tick` increments `cnt`. When it reaches `TURN_FRAMES`, go to IDLE.
- **Player interaction:** the two players may turn in the same cycle. Neither FSM depends on the other's state.

## Timing
- **Reset values:** `sprite1_facing_right`=1, `sprite2_facing_right`=0, both `turning`=0, both `turn_start`=0, both FSMs in IDLE, `cnt`=0, `p1_left`=1.
- **Registered signals:** all outputs and `p1_left` are registered.
- **Position update:** a position change is reflected in `p1_left` 1 cycle later. The FSM reacts the following cycle.
- **Facing flip:**
  - `sprite*_facing_right` and `turn_start` update in the cycle after the qualifying `frame_tick`.
  - `turning` rises in that same cycle.
  - `turning` falls in the cycle after the `TURN_FRAMES`-th tick counted in TURNING.
- **Minimum latency:** from a stable crossing to the flip, `HYST_FRAMES` ticks (with `FACING_HYST_EN` defined).
- **`turn_start`:** exactly one cycle wide per flip.
- **Boundary conditions:**
  - **Equal x or separation ≤ `DEADBAND`:** `p1_left` holds, so there is no flicker.
  - **`reset` mid-PENDING or mid-TURNING:** returns to reset values on the next edge, regardless of `frame_tick`.
  - **Crossing reverts while TURNING:** the turn completes. IDLE then detects the mismatch and starts a new PENDING.
  - **`frame_tick` coincident with reset:** reset wins.

## Configuration
- **`FACING_HYST_EN` defined:** PENDING behaves as described above.
- **`FACING_HYST_EN` undefined:**
  - `HYST_FRAMES` is ignored.
  - PENDING transitions to TURNING on the first `frame_tick` with busy=0.
  - The deadband and the TURNING duration are unchanged.

## Test plan
- **Reset:** assert `reset` with x1=10, x2=100, then idle 5 frames → facing1=1, facing2=0, turning=00, no `turn_start`.
- **Clean crossing:** set x1=100, x2=10 (defaults, `FACING_HYST_EN` defined).
  - Facings flip to 0/1 one cycle after the 3rd `frame_tick`.
  - Both `turn_start` pulse for 1 cycle.
  - Both `turning` stay high for 4 ticks, then fall.
- **Deadband hold:** x1=50, x2=51 from reset → `p1_left` stays 1, no turn.
  - Then x1=52, x2=50 (difference 2, not > `DEADBAND`) → still no turn.
  - Then x1=53 → PENDING begins.
- **Busy blocks turn:** crossing with `p1_busy`=1 for 5 ticks.
  - Player 2 turns after 3 ticks.
  - Player 1 turns 3 ticks after `p1_busy` falls.
- **Abort:** cross for 2 ticks, then restore the original positions → no flip, FSM back in IDLE, `cnt` cleared.
  - A new crossing again needs 3 full ticks.
- **Macro off:** with `FACING_HYST_EN` undefined, a crossing flips facing one cycle after the first `frame_tick`.
- **Reset mid-turn:** assert `reset` on turn tick 2 → outputs return to reset values next cycle.
